// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a column shift register turn a raster
// pixel stream into packed 144-bit windows. Optional build macro: CONV_WIN_STRIDE2_EN (adds stride2).
module conv_window_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [143:0] win_out,
  output logic         win_valid,
  input  logic         win_ready,
  output logic         busy,
  output logic         done
`ifdef CONV_WIN_STRIDE2_EN
  ,
  input  logic         stride2
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [15:0]        lb0 [IMG_W];
  logic [15:0]        lb1 [IMG_W];
  logic [1:0][47:0]   sr;        // two older columns {top,mid,bot}; sr[1] is the newer
  logic [47:0]        ncol;
  logic [143:0]       win_nxt;
  logic               accept, last_pix, emit, stride_ok, drain_exit;

  assign pix_ready = (state == STREAM) && (!win_valid || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign last_pix  = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
  assign busy      = (state != IDLE);
  assign ncol      = {lb1[col], lb0[col], pix_in};
  assign win_nxt   = {sr[0][47:32], sr[1][47:32], ncol[47:32],
                      sr[0][31:16], sr[1][31:16], ncol[31:16],
                      sr[0][15:0],  sr[1][15:0],  ncol[15:0]};

`ifdef CONV_WIN_STRIDE2_EN
  logic stride_q;
  // Stride-2 keeps windows whose top-left is on an even row and column.
  assign stride_ok = !stride_q || (!row[0] && !col[0]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stride_q <= 1'b0;
    else if (state == IDLE && start) stride_q <= stride2;
`else
  assign stride_ok = 1'b1;
`endif

  // Column wrap guarantees c >= 2 windows never straddle a row boundary.
  assign emit = accept && (row >= RW'(2)) && (col >= CW'(2)) && stride_ok;

  always_comb begin
    state_nxt  = state;
    drain_exit = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (accept && last_pix) state_nxt = DRAIN;
      DRAIN: begin
        drain_exit = !win_valid || win_ready;
        if (drain_exit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_out   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= drain_exit;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (emit) begin
        win_out   <= win_nxt;
        win_valid <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  // Storage needs no reset: contents are always rewritten before they are emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_in;
      sr       <= {ncol, sr[1]};
    end
  end
endmodule

// File: doc/conv_window_3x3.md
# conv_window_3x3

Streaming 3x3 window generator sitting directly upstream of the 3x3 fp16 convolution stage. Accepts one 16-bit fp16 feature-map pixel per handshake in raster order and stores the two previous rows in internal line buffers. Emits every valid 3x3 neighbourhood (no padding) as a 144-bit packed window whose layout matches the convolution stage's `im` operand. Pixels are treated as opaque 16-bit words; no arithmetic is performed on data.

## Interface

Parameters:
- `IMG_W`, 8: frame width in pixels; legal range 3..1024.
- `IMG_H`, 8: frame height in pixels; legal range 3..1024.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `start`  in  1  single-cycle pulse; begins a frame when idle.
- `pix_in`  in  16  fp16 pixel, raster order.
- `pix_valid`  in  1  `pix_in` valid.
- `pix_ready`  out  1  block accepts `pix_in` this cycle.
- `win_out`  out  144  packed window {p0..p8}: p0 in [143:128] = top-left, row-major, p8 in [15:0] = bottom-right.
- `win_valid`  out  1  `win_out` holds an unconsumed window.
- `win_ready`  in  1  downstream takes the window.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  single-cycle pulse when the frame is fully emitted and consumed.
- `stride2`  in  1  present only with `CONV_WIN_STRIDE2_EN` (see Configuration).

## Operation

- States: IDLE, STREAM, DRAIN.
  - IDLE: `pix_ready`=0. `start`=1 -> STREAM; row/col counters cleared.
  - STREAM: accept when `pix_valid && pix_ready`. After the accept of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: `pix_ready`=0. When `win_valid`=0 (or is cleared this cycle by `win_ready`) -> IDLE, pulsing `done` on that transition cycle.
- `start` outside IDLE is ignored.
- `pix_ready` = STREAM && (!`win_valid` || `win_ready`); single-entry output register; no bubble under continuous flow.
- On accept at (row r, col c):
  - line buffer 1[c] <= line buffer 0[c].
  - line buffer 0[c] <= `pix_in`.
  - 3x3 column shift register shifts left; new column = {lb1[c], lb0[c], `pix_in`} (top to bottom).
  - Column counter wraps at IMG_W-1, then row increments.
- A window is emitted when r >= 2 and c >= 2. `win_out` is loaded with the post-shift window and `win_valid` is set. The window is centred at (r-1, c-1).
- Column shift contents straddling a row boundary are never emitted (guaranteed by the c >= 2 condition).
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- `win_valid` clears on `win_ready` unless a new window loads on the same edge.
- `win_out` holds its value when not loading.

## Timing

- Reset values: `pix_ready`=0, `win_valid`=0, `win_out`=0, `busy`=0, `done`=0. Counters and state are cleared; line buffer contents are don't-care.
- `busy` rises the cycle after `start`; `pix_ready` rises the same cycle.
- Latency: `win_valid` rises one cycle after the accept edge of the completing pixel.
- Sustained throughput: 1 pixel/cycle with `win_ready` held 1.
- `win_valid`=1 && `win_ready`=0 stalls input; `win_out` is stable while stalled.
- `done` asserts the cycle after the last window handshake (or after the last pixel accept, if the final window was already consumed); `busy` falls with `done`.
- Reset mid-frame returns the block to IDLE immediately; the partial frame is discarded; no `done`.

## Configuration

- `CONV_WIN_STRIDE2_EN` defined:
  - `stride2` port exists and is sampled at `start`.
  - When `stride2`=1, windows are emitted only when (r-2) and (c-2) are both even; ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2) windows per frame.
  - Non-emitted positions still update the line buffers.
- `CONV_WIN_STRIDE2_EN` undefined: no `stride2` port; stride is fixed at 1.

## Test plan

- IMG_W=IMG_H=4, pixels 16'h0000..16'h000F, `win_ready`=1 -> 4 windows. First = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,A,B,D,E,F}. `done` 1 cycle after the last pixel accept.
- Same frame, `win_ready` toggling 1-of-3 cycles -> identical 4 windows, in order; `pix_ready`=0 whenever `win_valid && !win_ready`; no window lost or duplicated.
- IMG_W=IMG_H=3, pixels 16'h3C00..16'h4880 in the convolution-stage fp16 test order -> exactly one window, equal to {3C00,4000,4200,4400,4500,4600,4700,4800,4880}.
- `start` pulsed during STREAM, then `rst_n` low after 6 pixels -> second `start` ignored; after reset all outputs are 0 and state is IDLE; next frame is correct from its first window.
- `CONV_WIN_STRIDE2_EN`, IMG_W=IMG_H=5, `stride2`=1, pixels 0..24 -> 4 windows, centred at (1,1), (1,3), (3,1), (3,3); first = {0,1,2,5,6,7,10,11,12}.
